// File: rtl/tvp5147_init_sequencer.sv
// Power-up register loader for a TVP5147M1 decoder: writes a fixed register table
// over an external I2C master, optionally reads each entry back, and retries failures.
module tvp5147_init_sequencer #(
   parameter logic [7:0]  DEV_ADDR     = 8'hB8,
   parameter logic [19:0] PWR_DELAY    = 20'd100000,
   parameter int          RETRY_MAX    = 3,
   parameter logic [15:0] BUSY_TIMEOUT = 16'd1000,
   parameter int          VERIFY       = 1
) (
   input  logic       i_clk,
   input  logic       reset,
   input  logic       start,
   output logic [7:0] o_addr_w_rw,
   output logic [7:0] o_sub_addr,
   output logic [7:0] o_data_write,
   output logic       o_req_trans,
   input  logic [7:0] i_data_out,
   input  logic       i_valid_out,
   input  logic       i_busy,
   input  logic       i_nack,
   output logic       done,
   output logic       error,
   output logic       o_busy,
   output logic [2:0] o_index
);

   localparam int NUM_ENTRIES = 5;
   localparam logic [7:0] RETRY_LIM = 8'(RETRY_MAX);

   localparam logic [3:0] S_IDLE          = 4'd0;
   localparam logic [3:0] S_PWR_WAIT      = 4'd1;
   localparam logic [3:0] S_WR_REQ        = 4'd2;
   localparam logic [3:0] S_WR_WAIT_HI    = 4'd3;
   localparam logic [3:0] S_WR_WAIT_LO    = 4'd4;
   localparam logic [3:0] S_RD_REQ        = 4'd5;
   localparam logic [3:0] S_RD_WAIT_HI    = 4'd6;
   localparam logic [3:0] S_RD_WAIT_VALID = 4'd7;
   localparam logic [3:0] S_CHECK         = 4'd8;
   localparam logic [3:0] S_NEXT          = 4'd9;
   localparam logic [3:0] S_DONE          = 4'd10;
   localparam logic [3:0] S_ERROR         = 4'd11;

   // {sub_addr, data} for each table entry
   function automatic logic [15:0] table_entry(input logic [2:0] idx);
      case (idx)
         3'd0:    table_entry = {8'h00, 8'h00};
         3'd1:    table_entry = {8'h02, 8'h00};
         3'd2:    table_entry = {8'h03, 8'h6D};
         3'd3:    table_entry = {8'h0D, 8'h47};
         3'd4:    table_entry = {8'h34, 8'h11};
         default: table_entry = 16'h0000;
      endcase
   endfunction

   logic [3:0]  state;
   logic [19:0] pwr_cnt;
   logic [15:0] to_cnt;
   logic [7:0]  retry_cnt;
   logic        nack_lat;
   logic [7:0]  rd_data;
   logic [15:0] entry;
   logic        fail;

   assign entry  = table_entry(o_index);
   assign done   = (state == S_DONE);
   assign error  = (state == S_ERROR);
   assign o_busy = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

   // A NACK coinciding with valid read data still counts as a failed read.
   always_comb begin
      fail = 1'b0;
      case (state)
         S_WR_WAIT_LO:    fail = !i_busy && (nack_lat || i_nack);
         S_RD_WAIT_VALID: fail = i_valid_out ? (nack_lat || i_nack) : !i_busy;
         S_CHECK:         fail = (rd_data != entry[7:0]);
         default:         fail = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      o_req_trans <= 1'b0;
      if (reset) begin
         state        <= S_IDLE;
         pwr_cnt      <= '0;
         to_cnt       <= '0;
         retry_cnt    <= '0;
         nack_lat     <= 1'b0;
         rd_data      <= '0;
         o_index      <= '0;
         o_addr_w_rw  <= '0;
         o_sub_addr   <= '0;
         o_data_write <= '0;
      end else if (fail) begin
         if (retry_cnt < RETRY_LIM) begin
            retry_cnt <= retry_cnt + 8'd1;
            state     <= S_WR_REQ;
         end else begin
            state <= S_ERROR;
         end
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state     <= S_PWR_WAIT;
                  pwr_cnt   <= '0;
                  o_index   <= '0;
                  retry_cnt <= '0;
               end
            end
            S_PWR_WAIT: begin
               if (pwr_cnt + 20'd1 >= PWR_DELAY) state <= S_WR_REQ;
               else pwr_cnt <= pwr_cnt + 20'd1;
            end
            S_WR_REQ: begin
               if (!i_busy) begin
                  o_addr_w_rw  <= DEV_ADDR;
                  o_sub_addr   <= entry[15:8];
                  o_data_write <= entry[7:0];
                  o_req_trans  <= 1'b1;
                  nack_lat     <= 1'b0;
                  to_cnt       <= '0;
                  state        <= S_WR_WAIT_HI;
               end
            end
            S_WR_WAIT_HI: begin
               if (i_busy) begin
                  nack_lat <= i_nack;
                  state    <= S_WR_WAIT_LO;
               end else if (to_cnt + 16'd1 >= BUSY_TIMEOUT) begin
                  state <= S_ERROR;
               end else begin
                  to_cnt <= to_cnt + 16'd1;
               end
            end
            S_WR_WAIT_LO: begin
               if (i_nack) nack_lat <= 1'b1;
               if (!i_busy) state <= (VERIFY != 0) ? S_RD_REQ : S_NEXT;
            end
            S_RD_REQ: begin
               if (!i_busy) begin
                  o_addr_w_rw  <= DEV_ADDR | 8'h01;
                  o_sub_addr   <= entry[15:8];
                  o_data_write <= entry[7:0];
                  o_req_trans  <= 1'b1;
                  nack_lat     <= 1'b0;
                  to_cnt       <= '0;
                  state        <= S_RD_WAIT_HI;
               end
            end
            S_RD_WAIT_HI: begin
               if (i_busy) begin
                  nack_lat <= i_nack;
                  state    <= S_RD_WAIT_VALID;
               end else if (to_cnt + 16'd1 >= BUSY_TIMEOUT) begin
                  state <= S_ERROR;
               end else begin
                  to_cnt <= to_cnt + 16'd1;
               end
            end
            S_RD_WAIT_VALID: begin
               if (i_valid_out) begin
                  rd_data <= i_data_out;
                  state   <= S_CHECK;
               end else if (i_nack) begin
                  nack_lat <= 1'b1;
               end
            end
            S_CHECK: state <= S_NEXT;
            S_NEXT: begin
               retry_cnt <= '0;
               if (o_index == 3'(NUM_ENTRIES - 1)) begin
                  state <= S_DONE;
               end else begin
                  o_index <= o_index + 3'd1;
                  state   <= S_WR_REQ;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tvp5147_init_sequencer.sv
// Bench for tvp5147_init_sequencer: a randomized-timing I2C slave model plus a
// transaction-list reference model built from the table and retry rules.
module tb_tvp5147_init_sequencer;

   localparam int PD = 10;
   localparam int RM = 3;
   localparam int BT = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] o_addr_w_rw, o_sub_addr, o_data_write;
   logic       o_req_trans;
   logic [7:0] i_data_out = 8'h00;
   logic       i_valid_out = 1'b0;
   logic       i_busy = 1'b0;
   logic       i_nack = 1'b0;
   logic       done, error, o_busy;
   logic [2:0] o_index;

   tvp5147_init_sequencer #(
      .DEV_ADDR(8'hB8), .PWR_DELAY(20'(PD)), .RETRY_MAX(RM),
      .BUSY_TIMEOUT(16'(BT)), .VERIFY(1)
   ) dut (
      .i_clk(clk), .reset(reset), .start(start),
      .o_addr_w_rw(o_addr_w_rw), .o_sub_addr(o_sub_addr), .o_data_write(o_data_write),
      .o_req_trans(o_req_trans), .i_data_out(i_data_out), .i_valid_out(i_valid_out),
      .i_busy(i_busy), .i_nack(i_nack), .done(done), .error(error),
      .o_busy(o_busy), .o_index(o_index)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] tsub [5] = '{8'h00, 8'h02, 8'h03, 8'h0D, 8'h34};
   logic [7:0] tdat [5] = '{8'h00, 8'h00, 8'h6D, 8'h47, 8'h11};

   // Fault plan shared by the slave model and the reference model
   int nack_entry = -1, nack_count = 0, bad_entry = -1, bad_count = 0;
   bit rd_nack_mode = 1'b0, no_busy = 1'b0, slave_rst = 1'b1;

   function automatic int entry_of(input logic [7:0] sub);
      for (int k = 0; k < 5; k++) if (tsub[k] == sub) return k;
      return -1;
   endfunction

   // I2C slave model, evaluated on the falling edge
   int          phase = 0, cnt = 0, e = 0;
   bit          do_nack = 1'b0, is_rd = 1'b0;
   logic [7:0]  rd_val = 8'h00;
   logic [23:0] cur = 24'h0;
   logic [7:0]  mem [256];
   int          wr_seen [5], rd_seen [5];
   logic [23:0] obs_q [$];
   int          req_cyc = 0, first_req_cyc = 0;

   always @(negedge clk) begin
      if (slave_rst) begin
         phase = 0; i_busy = 1'b0; i_nack = 1'b0; i_valid_out = 1'b0;
      end else begin
         i_nack = 1'b0;
         i_valid_out = 1'b0;
         case (phase)
            0: if (o_req_trans === 1'b1) begin
               cur = {o_addr_w_rw, o_sub_addr, o_data_write};
               if (obs_q.size() == 0) first_req_cyc = cyc;
               obs_q.push_back(cur);
               req_cyc = cyc;
               e = entry_of(o_sub_addr);
               is_rd = o_addr_w_rw[0];
               do_nack = 1'b0;
               if (e >= 0) begin
                  if (!is_rd) begin
                     wr_seen[e]++;
                     do_nack = (e == nack_entry) && (wr_seen[e] <= nack_count);
                     if (!do_nack) mem[o_sub_addr] = o_data_write;
                  end else begin
                     rd_seen[e]++;
                     rd_val = mem[o_sub_addr];
                     if (e == bad_entry && rd_seen[e] <= bad_count) begin
                        if (rd_nack_mode) do_nack = 1'b1;
                        else rd_val = rd_val ^ 8'h01;
                     end
                  end
               end
               if (!no_busy) begin phase = 1; cnt = int'($urandom_range(0, 2)); end
            end
            1: if (cnt == 0) begin
               i_busy = 1'b1; phase = 2; cnt = int'($urandom_range(2, 5));
            end else cnt--;
            default: if (cnt == 0) begin
               check("addr/sub/data held while busy", {o_addr_w_rw, o_sub_addr, o_data_write}, cur);
               i_busy = 1'b0; phase = 0;
            end else begin
               cnt--;
               if (cnt == 0) begin
                  if (do_nack) i_nack = 1'b1;
                  if (is_rd) begin i_valid_out = 1'b1; i_data_out = rd_val; end
               end
            end
         endcase
      end
   end

   // Reference model: expected request list and final status from the retry rules
   logic [23:0] exp_q [$];
   bit          exp_err;
   int          exp_idx;

   task automatic build_model();
      int wr [5] = '{default: 0};
      int rd [5] = '{default: 0};
      int tries;
      bit ok;
      exp_q.delete(); exp_err = 1'b0; exp_idx = 0;
      for (int k = 0; k < 5; k++) begin
         tries = 0;
         forever begin
            wr[k]++;
            exp_q.push_back({8'hB8, tsub[k], tdat[k]});
            ok = !(k == nack_entry && wr[k] <= nack_count);
            if (ok) begin
               rd[k]++;
               exp_q.push_back({8'hB9, tsub[k], tdat[k]});
               ok = !(k == bad_entry && rd[k] <= bad_count);
            end
            if (ok) break;
            tries++;
            if (tries > RM) begin exp_err = 1'b1; exp_idx = k; return; end
         end
      end
      exp_idx = 4;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin wr_seen[k] = 0; rd_seen[k] = 0; end
      obs_q.delete();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_seq(input string tag);
      int guard;
      int start_cyc;
      logic [31:0] o;
      build_model();
      start_cyc = cyc + 1;
      pulse_start();
      start_cyc = start_cyc - 1;
      guard = 0;
      while (done !== 1'b1 && error !== 1'b1 && guard < 5000) begin
         @(negedge clk); guard++;
      end
      check($sformatf("%s finished in budget", tag), (guard < 5000) ? 1 : 0, 1);
      check($sformatf("%s request count", tag), obs_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         o = (i < obs_q.size()) ? {8'h00, obs_q[i]} : 32'hxxxxxxxx;
         check($sformatf("%s request %0d", tag, i), o, {8'h00, exp_q[i]});
      end
      check($sformatf("%s done", tag), done, !exp_err);
      check($sformatf("%s error", tag), error, exp_err);
      check($sformatf("%s index", tag), o_index, exp_idx);
      check($sformatf("%s o_busy", tag), o_busy, 0);
      check($sformatf("%s power-up wait", tag),
            (first_req_cyc - start_cyc >= PD + 1 && first_req_cyc - start_cyc <= PD + 3) ? 1 : 0, 1);
   endtask

   task automatic clear_faults();
      nack_entry = -1; nack_count = 0; bad_entry = -1; bad_count = 0;
      rd_nack_mode = 1'b0; no_busy = 1'b0;
   endtask

   initial begin
      int guard;
      int n;
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("reset outputs",
            {o_req_trans, done, error, o_busy, o_index, o_addr_w_rw, o_sub_addr, o_data_write}, 0);
      reset = 1'b0;
      slave_rst = 1'b0;

      clear_faults();
      run_seq("clean");

      clear_faults(); nack_entry = 2; nack_count = 1;
      run_seq("nack entry2 once");

      clear_faults(); nack_entry = 3; nack_count = 99;
      run_seq("persistent nack entry3");

      clear_faults(); bad_entry = 1; bad_count = 1;
      run_seq("bad readback entry1");

      clear_faults(); bad_entry = 4; bad_count = 2; rd_nack_mode = 1'b1;
      run_seq("nack with valid entry4");

      // Busy never rises: timeout measured from the request pulse
      clear_faults(); no_busy = 1'b1;
      pulse_start();
      guard = 0;
      while (error !== 1'b1 && guard < 5000) begin @(negedge clk); guard++; end
      check("timeout error", error, 1);
      check("timeout latency", cyc - req_cyc, BT);
      check("timeout request count", obs_q.size(), 1);
      check("timeout index", o_index, 0);
      check("timeout done", done, 0);
      no_busy = 1'b0;

      // Reset while entry 2 write is in flight
      clear_faults();
      pulse_start();
      guard = 0;
      while (!(i_busy === 1'b1 && obs_q.size() > 0 && obs_q[obs_q.size()-1] === {8'hB8, 8'h03, 8'h6D})
             && guard < 5000) begin
         @(negedge clk); guard++;
      end
      @(posedge clk);
      @(negedge clk);
      check("pre-reset index", o_index, 2);
      check("pre-reset o_busy", o_busy, 1);
      reset = 1'b1; slave_rst = 1'b1;
      @(negedge clk);
      check("mid-transaction reset outputs",
            {o_req_trans, done, error, o_busy, o_index, o_addr_w_rw, o_sub_addr, o_data_write}, 0);
      reset = 1'b0; slave_rst = 1'b0;
      n = obs_q.size();
      repeat (40) @(negedge clk);
      check("no request without start", obs_q.size(), n);
      run_seq("restart after reset");

      for (int r = 0; r < 6; r++) begin
         clear_faults();
         nack_entry   = int'($urandom_range(0, 5));
         nack_count   = int'($urandom_range(0, 5));
         bad_entry    = int'($urandom_range(0, 5));
         bad_count    = int'($urandom_range(0, 5));
         rd_nack_mode = 1'($urandom_range(0, 1));
         run_seq($sformatf("random%0d", r));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
